mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage pipeline, sitting directly downstream of the EX/M pipeline register and upstream of the M/WB register. It consumes the registered EX results (ALU address/result, store data, control, destination index, branch info), performs word or byte loads and stores against a variable-latency data memory through a req/ack handshake, and stalls the front of the pipeline while an access is outstanding. It also resolves conditional branches and formats load data for write-back.

## Interface
- TIMEOUT, 16: max BUSY cycles without ack before the access is aborted (1..255).
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- address_in  in  32  ALU result from EX/M; memory byte address or write-back value.
- next_pc_in  in  32  branch target from EX/M.
- ALU_zero_in  in  1  ALU zero flag from EX/M.
- data_in  in  32  store data from EX/M.
- control_in  in  6  [0] mem_read, [1] mem_write, [2] byte access, [3] branch, [4] reg_write, [5] mem_to_reg.
- rgD_index_in  in  5  destination register index from EX/M.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address {address[31:2],2'b00}.
- mem_wdata  out  32  write data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  access complete; rdata valid same cycle.
- mem_rdata  in  32  read data.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/M write enables.
- branch_taken  out  1  control_in[3] & ALU_zero_in (combinational).
- branch_target  out  32  next_pc_in (combinational).
- wb_data  out  32  result toward M/WB.
- wb_rd  out  5  rgD_index_in pass-through.
- wb_reg_write  out  1  control_in[4] & ~stall.
- mem_error  out  1  sticky: misaligned word access or timeout.

## Operation
- FSM states IDLE, BUSY, DONE; reset → IDLE.
- IDLE: if mem_read|mem_write: stall=1 (combinational); if word access with address_in[1:0]≠0 → set mem_error, load buffer=0, go DONE without request; else register mem_addr/mem_wdata/mem_be/mem_we, set mem_req=1, clear timeout counter, go BUSY. Otherwise stall=0, stay IDLE.
- BUSY: stall=1; mem_req, mem_we, mem_addr, mem_wdata, mem_be held stable. On mem_ack: capture formatted mem_rdata into load buffer, mem_req=0, go DONE. Counter increments each BUSY cycle without ack; when it reaches TIMEOUT-1 without ack: mem_req=0, mem_error=1, load buffer=0, go DONE.
- DONE: stall=0 for exactly one cycle (pipeline advances), unconditional → IDLE.
- mem_read and mem_write both set: treated as a write.
- Store word: mem_be=4'hF, mem_wdata=data_in. Store byte: mem_be=4'b0001<<address[1:0], mem_wdata={4{data_in[7:0]}}.
- Load word: buffer=mem_rdata. Load byte: lane address[1:0] (little-endian, lane 0 = bits 7:0), sign-extended to 32.
- wb_data = load buffer when mem_read & mem_to_reg, else address_in.
- mem_ack in IDLE or DONE ignored. mem_error cleared only by reset.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, load buffer 0, counter 0, mem_error 0; stall/wb/branch outputs follow combinational rules from inputs.
- Reset during BUSY: mem_req drops immediately (asynchronous), no completion.
- Non-memory instruction: zero added latency, stall never asserted.
- Memory op, ack in first BUSY cycle: cycle 0 IDLE (stall=1), cycle 1 BUSY (req=1, ack), cycle 2 DONE (stall=0, wb_data valid); minimum 3 cycles per access.
- Ack after k BUSY cycles: 2+k cycles total. Timeout: DONE reached after TIMEOUT BUSY cycles.
- Misaligned word: cycle 0 IDLE, cycle 1 DONE; no mem_req ever.

## Test plan
- ALU op, control=6'b010000, address_in=0x1234 → stall=0, wb_data=0x1234, wb_reg_write=1, mem_req never high.
- Load word 0x100, ack after 3 BUSY cycles with rdata=0xCAFEF00D → mem_addr=0x100, req high 3 cycles, DONE wb_data=0xCAFEF00D, stall high 4 cycles.
- Load byte address 0x103, rdata=0x80000000, ack immediate → wb_data=0xFFFFFF80.
- Store byte address 0x202, data_in=0xAB → mem_we=1, mem_be=4'b0100, mem_wdata=0xABABABAB, mem_addr=0x200.
- Load word address 0x101 → no req, mem_error=1 next cycle, wb_data=0; then no ack for TIMEOUT=16 on aligned load → DONE after 16 BUSY cycles, mem_error stays 1.
- Branch with ALU_zero_in=1, next_pc_in=0x40 → branch_taken=1, branch_target=0x40; assert reset mid-BUSY → mem_req=0 immediately, state IDLE.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage_if: req/ack data-memory bus between the memory stage and data memory.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, mem_be, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; word/byte loads and stores over a req/ack bus,
// stalls the front end while an access is outstanding, resolves branches.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        address_in,
    input  logic [31:0]        next_pc_in,
    input  logic               ALU_zero_in,
    input  logic [31:0]        data_in,
    input  logic [5:0]         control_in,
    input  logic [4:0]         rgD_index_in,
    mem_stage_if.master        mem,
    output logic               stall,
    output logic               branch_taken,
    output logic [31:0]        branch_target,
    output logic [31:0]        wb_data,
    output logic [4:0]         wb_rd,
    output logic               wb_reg_write,
    output logic               mem_error
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr, r_wdata, r_load;
    logic [3:0]  r_be;
    logic        r_we, r_err;
    logic        w_mem_op, w_misaligned, w_timeout;
    logic [7:0]  w_byte;
    logic [31:0] w_rdata_fmt;

    assign w_mem_op     = control_in[0] | control_in[1];
    assign w_misaligned = ~control_in[2] & (address_in[1:0] != 2'b00);
    assign w_timeout    = ~mem.mem_ack & (r_cnt == 8'(TIMEOUT - 1));
    // EX/M is frozen while stalled, so the live address still selects the load lane
    assign w_byte       = mem.mem_rdata[{address_in[1:0], 3'b000} +: 8];
    assign w_rdata_fmt  = control_in[2] ? {{24{w_byte[7]}}, w_byte} : mem.mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (w_mem_op ? (w_misaligned ? DONE : BUSY) : IDLE) :
                 (r_state == BUSY) ? ((mem.mem_ack | w_timeout) ? DONE : BUSY) : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_load  <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && w_mem_op) begin
                if (w_misaligned) begin
                    r_err  <= 1'b1;
                    r_load <= '0;
                end else begin
                    r_addr  <= {address_in[31:2], 2'b00};
                    r_we    <= control_in[1];
                    r_be    <= control_in[2] ? 4'b0001 << address_in[1:0] : 4'hF;
                    r_wdata <= control_in[2] ? {4{data_in[7:0]}} : data_in;
                    r_cnt   <= '0;
                end
            end
            if (r_state == BUSY) begin
                if (mem.mem_ack) r_load <= w_rdata_fmt;
                else if (w_timeout) begin
                    r_err  <= 1'b1;
                    r_load <= '0;
                end else r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        stall        = (r_state == BUSY) | ((r_state == IDLE) & w_mem_op);
        wb_reg_write = control_in[4] & ~stall;
        wb_data      = (control_in[0] & control_in[5]) ? r_load : address_in;
    end

    assign mem.mem_req    = (r_state == BUSY);
    assign mem.mem_we     = r_we;
    assign mem.mem_addr   = r_addr;
    assign mem.mem_wdata  = r_wdata;
    assign mem.mem_be     = r_be;
    assign mem_error      = r_err;
    assign branch_taken   = control_in[3] & ALU_zero_in;
    assign branch_target  = next_pc_in;
    assign wb_rd          = rgD_index_in;
endmodule
